// File: rtl/err_stat_if.sv
// Sample-pair and result bundle for err_stat_monitor.
// The bench or stimulus side uses master; the monitor uses slave.
interface err_stat_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                           start;
  logic [CNT_W-1:0]               win_len;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [DATA_W-1:0]       appr;
  logic signed [DATA_W-1:0]       accu;
  logic                           busy;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [DATA_W+CNT_W:0]   err_sum;
  logic [2*DATA_W+CNT_W-1:0]      err_sq_sum;
  logic [DATA_W+CNT_W-1:0]        abs_accu_sum;
  logic [CNT_W-1:0]               er0_cnt;
  logic [CNT_W-1:0]               er1_cnt;

  modport master (
    output start, win_len, in_valid, appr, accu, out_ready,
    input  in_ready, busy, out_valid, err_sum, err_sq_sum, abs_accu_sum, er0_cnt, er1_cnt
  );

  modport slave (
    input  start, win_len, in_valid, appr, accu, out_ready,
    output in_ready, busy, out_valid, err_sum, err_sq_sum, abs_accu_sum, er0_cnt, er1_cnt
  );
endinterface

// File: rtl/err_stat_monitor.sv
// Windowed error statistics between an approximate unit and its accurate reference.
// Optional macro ERR_SQ_EN adds the pipelined squared-error accumulator and the DRAIN state.
module err_stat_monitor #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int THRESH = 16
) (
  input logic       clk,
  input logic       rst_n,
  err_stat_if.slave mon
);
  localparam int ESUM_W = DATA_W + 1 + CNT_W;
  localparam int SQ_W   = 2*DATA_W + CNT_W;
  localparam int ABS_W  = DATA_W + CNT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          win_len_reg, cnt_reg;
  logic signed [ESUM_W-1:0]  err_sum_reg;
  logic [ABS_W-1:0]          abs_sum_reg;
  logic [CNT_W-1:0]          er0_reg, er1_reg;
  logic                      in_ready, busy, out_valid;
  logic                      accept, start_ok, last;
  logic signed [DATA_W:0]    err, accu_ext;
  logic [DATA_W:0]           abs_accu;
  logic                      hi_diff;

  assign accept   = mon.in_valid & in_ready;
  assign start_ok = (state_reg == IDLE) & mon.start;
  assign last     = accept & (cnt_reg == win_len_reg - CNT_W'(1));

  assign err      = $signed({mon.appr[DATA_W-1], mon.appr}) - $signed({mon.accu[DATA_W-1], mon.accu});
  assign accu_ext = $signed({mon.accu[DATA_W-1], mon.accu});
  // One extra bit so that the most negative reference negates exactly.
  assign abs_accu = accu_ext[DATA_W] ? $unsigned(-accu_ext) : $unsigned(accu_ext);
  assign hi_diff  = mon.appr[DATA_W-1:THRESH] != mon.accu[DATA_W-1:THRESH];

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mon.start) state_next = (mon.win_len == '0) ? REPORT : ACCUM;
`ifdef ERR_SQ_EN
      ACCUM:   if (last) state_next = DRAIN;
`else
      ACCUM:   if (last) state_next = REPORT;
`endif
      DRAIN:   state_next = REPORT;
      REPORT:  if (mon.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ACCUM);
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == REPORT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len_reg <= '0;
      cnt_reg     <= '0;
      err_sum_reg <= '0;
      abs_sum_reg <= '0;
      er0_reg     <= '0;
      er1_reg     <= '0;
    end else if (start_ok) begin
      win_len_reg <= mon.win_len;
      cnt_reg     <= '0;
      err_sum_reg <= '0;
      abs_sum_reg <= '0;
      er0_reg     <= '0;
      er1_reg     <= '0;
    end else if (accept) begin
      cnt_reg     <= cnt_reg + CNT_W'(1);
      err_sum_reg <= err_sum_reg + ESUM_W'(err);
      abs_sum_reg <= abs_sum_reg + ABS_W'(abs_accu);
      er0_reg     <= er0_reg + CNT_W'(err != '0);
      er1_reg     <= er1_reg + CNT_W'(hi_diff);
    end
  end

`ifdef ERR_SQ_EN
  logic signed [2*DATA_W+1:0] sq_reg;
  logic                       sq_vld_reg;
  logic [SQ_W-1:0]            sq_sum_reg;

  // The product is registered first; its accumulation trails by one cycle, hence DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_reg     <= '0;
      sq_vld_reg <= 1'b0;
      sq_sum_reg <= '0;
    end else if (start_ok) begin
      sq_reg     <= '0;
      sq_vld_reg <= 1'b0;
      sq_sum_reg <= '0;
    end else begin
      sq_vld_reg <= accept;
      if (accept)     sq_reg     <= err * err;
      if (sq_vld_reg) sq_sum_reg <= sq_sum_reg + SQ_W'($unsigned(sq_reg));
    end
  end

  assign mon.err_sq_sum = sq_sum_reg;
`else
  assign mon.err_sq_sum = '0;
`endif

  assign mon.in_ready     = in_ready;
  assign mon.busy         = busy;
  assign mon.out_valid    = out_valid;
  assign mon.err_sum      = err_sum_reg;
  assign mon.abs_accu_sum = abs_sum_reg;
  assign mon.er0_cnt      = er0_reg;
  assign mon.er1_cnt      = er1_reg;
endmodule

// File: tb/tb_err_stat_monitor.sv
// Randomized and directed windows for err_stat_monitor against a queue-based
// arithmetic reference model.
module tb_err_stat_monitor;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TH = 16;
`ifdef ERR_SQ_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  err_stat_if #(.DATA_W(DW), .CNT_W(CW)) mon_if ();

  err_stat_monitor #(.DATA_W(DW), .CNT_W(CW), .THRESH(TH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon_if.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic signed [DW-1:0] pa[$], pc[$];   // pairs offered to the DUT
  logic signed [DW-1:0] qa[$], qc[$];   // pairs actually accepted
  logic signed [127:0]  m_esum, m_sq, m_abs;
  int                   m_er0, m_er1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_calc();
    logic signed [127:0] a, c, e;
    logic [DW-1:0] ua, uc;
    m_esum = 0; m_sq = 0; m_abs = 0; m_er0 = 0; m_er1 = 0;
    for (int i = 0; i < qa.size(); i++) begin
      ua = qa[i];
      uc = qc[i];
      a = qa[i];
      c = qc[i];
      e = a - c;
      m_esum += e;
      m_sq   += e * e;
      m_abs  += (c < 0) ? -c : c;
      if (a != c) m_er0++;
      if (ua[DW-1:TH] != uc[DW-1:TH]) m_er1++;
    end
  endfunction

  task automatic check_results(input string tag);
    logic signed [127:0] g;
    g = mon_if.err_sum;
    check({tag, "_err_sum"}, g, m_esum);
    check({tag, "_err_sq_sum"}, 128'(mon_if.err_sq_sum), SQ_EN ? m_sq : 128'(0));
    check({tag, "_abs_accu_sum"}, 128'(mon_if.abs_accu_sum), m_abs);
    check({tag, "_er0_cnt"}, 128'(mon_if.er0_cnt), 128'(m_er0));
    check({tag, "_er1_cnt"}, 128'(mon_if.er1_cnt), 128'(m_er1));
  endtask

  function automatic logic [DW-1:0] gen_val();
    case ($urandom_range(0, 5))
      0:       return 32'h7fff_ffff;
      1:       return 32'h8000_0000;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic gen_window(input int n);
    logic [DW-1:0] a, c;
    pa.delete(); pc.delete();
    for (int i = 0; i < n; i++) begin
      a = gen_val();
      case ($urandom_range(0, 3))
        0:       c = a;
        1:       c = a ^ ($urandom & 32'h0000_ffff);
        default: c = gen_val();
      endcase
      pa.push_back(a);
      pc.push_back(c);
    end
  endtask

  // Runs one window from IDLE; all driving and sampling on the falling edge.
  task automatic run_window(input int wl, input int hold, input string tag);
    int idx, guard, lat;
    check({tag, "_idle_busy"}, mon_if.busy, 0);
    mon_if.start = 1'b1;
    mon_if.win_len = CW'(wl);
    @(negedge clk);
    mon_if.start = 1'b0;
    mon_if.win_len = CW'($urandom);
    check({tag, "_busy_after_start"}, mon_if.busy, 1);
    check({tag, "_in_ready_after_start"}, mon_if.in_ready, (wl != 0) ? 1 : 0);
    qa.delete(); qc.delete();
    idx = 0; guard = 0;
    while (qa.size() < wl && guard < 4*wl + 50) begin
      mon_if.in_valid = ($urandom_range(0, 3) != 0);
      if (mon_if.in_valid) begin
        mon_if.appr = pa[idx];
        mon_if.accu = pc[idx];
        qa.push_back(pa[idx]);
        qc.push_back(pc[idx]);
        idx++;
      end else begin
        mon_if.appr = $urandom;
        mon_if.accu = $urandom;
      end
      check({tag, "_in_ready_accum"}, mon_if.in_ready, 1);
      @(negedge clk);
      guard++;
    end
    mon_if.in_valid = 1'b0;
    if (qa.size() < wl) check({tag, "_feed_timeout"}, 0, 1);
    lat = 0;
    while (!mon_if.out_valid && lat < 10) begin
      check({tag, "_in_ready_drain"}, mon_if.in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_result_latency"}, lat, (wl != 0 && SQ_EN) ? 1 : 0);
    check({tag, "_in_ready_report"}, mon_if.in_ready, 0);
    model_calc();
    check_results(tag);
    for (int h = 0; h < hold; h++) begin
      mon_if.in_valid = $urandom_range(0, 1);
      mon_if.appr = $urandom;
      mon_if.accu = $urandom;
      mon_if.start = $urandom_range(0, 1);
      mon_if.win_len = CW'($urandom_range(0, 5));
      @(negedge clk);
      check({tag, "_hold_busy"}, mon_if.busy, 1);
      check({tag, "_hold_out_valid"}, mon_if.out_valid, 1);
      check({tag, "_hold_in_ready"}, mon_if.in_ready, 0);
      check_results({tag, "_hold"});
    end
    mon_if.in_valid = 1'b0;
    mon_if.out_ready = 1'b1;
    mon_if.start = 1'b1;
    mon_if.win_len = CW'(3);
    @(negedge clk);
    mon_if.out_ready = 1'b0;
    mon_if.start = 1'b0;
    check({tag, "_ack_out_valid"}, mon_if.out_valid, 0);
    check({tag, "_ack_busy"}, mon_if.busy, 0);
    @(negedge clk);
    check({tag, "_ack_start_ignored"}, mon_if.busy, 0);
    check_results({tag, "_idle"});
  endtask

  initial begin
    logic signed [127:0] g;
    mon_if.start = 1'b0;
    mon_if.win_len = '0;
    mon_if.in_valid = 1'b0;
    mon_if.appr = '0;
    mon_if.accu = '0;
    mon_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    qa.delete(); qc.delete();
    model_calc();
    check("rst_busy", mon_if.busy, 0);
    check("rst_out_valid", mon_if.out_valid, 0);
    check("rst_in_ready", mon_if.in_ready, 0);
    check_results("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window
    pa = '{32'sd10, -32'sd5, 32'sd0};
    pc = '{32'sd7, -32'sd5, 32'sd4};
    run_window(3, 2, "basic");
    g = mon_if.err_sum;
    check("basic_err_sum_const", g, -128'sd1);
    check("basic_abs_const", 128'(mon_if.abs_accu_sum), 128'd16);

    // High-slice mismatch
    pa = '{32'h0001_0000};
    pc = '{32'h0};
    run_window(1, 1, "hislice");

    // Extremes
    pa = '{32'h7fff_ffff, 32'h7fff_ffff};
    pc = '{32'h8000_0000, 32'h8000_0000};
    run_window(2, 1, "extreme");

    // Zero window with start pulses during REPORT
    pa.delete(); pc.delete();
    run_window(0, 3, "zero");

    // Back-pressure: long REPORT hold
    gen_window(4);
    run_window(4, 5, "bp");

    // Mid-window reset
    mon_if.start = 1'b1;
    mon_if.win_len = CW'(10);
    @(negedge clk);
    mon_if.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mon_if.in_valid = 1'b1;
      mon_if.appr = $urandom;
      mon_if.accu = $urandom;
      @(negedge clk);
    end
    mon_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qc.delete();
    model_calc();
    for (int i = 0; i < 3; i++) begin
      check("midrst_out_valid", mon_if.out_valid, 0);
      check("midrst_busy", mon_if.busy, 0);
      check("midrst_in_ready", mon_if.in_ready, 0);
      check_results("midrst");
      @(negedge clk);
    end
    pa = '{32'sd3};
    pc = '{32'sd1};
    run_window(1, 0, "after_rst");
    g = mon_if.err_sum;
    check("after_rst_err_sum_const", g, 128'sd2);

    // Random windows
    for (int w = 0; w < 25; w++) begin
      int wl;
      wl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      gen_window(wl);
      run_window(wl, $urandom_range(0, 3), $sformatf("rnd%0d", w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
